// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the sequential instruction fetch unit.
package ysyx_25020047_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        EXEC,
        ERR
    } ifu_state_e;

    // A committed next PC is usable only when it lands on a word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25020047_watchdog.sv
// Response watchdog: counts cycles spent waiting for instruction memory
// and flags expiry once the count reaches TIMEOUT-1.
module ysyx_25020047_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Clear has priority over counting so a fresh request always starts at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_25020047_ifu_seq.sv
// Multi-cycle instruction fetch unit for the non-pipelined core: requests
// one instruction, hands it to IDU, then waits for the writeback commit.
module ysyx_25020047_ifu_seq
    import ysyx_25020047_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc,
    output logic [31:0]       snpc,
    input  logic              wb_valid,
    input  logic [31:0]       wb_dnpc,
    output logic              fetch_err,
    output logic [31:0]       fetch_cnt
);

    ifu_state_e state;
    ifu_state_e next_state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    assign wd_clear  = (state == REQ) && imem_req_valid && imem_req_ready;
    assign wd_enable = (state == WAIT);

    ysyx_25020047_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state selection; a response in WAIT wins over a simultaneous timeout.
    always_comb begin
        next_state = state;
        case (state)
            REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    next_state = HOLD;
                end else if (wd_expired) begin
                    next_state = ERR;
                end
            end
            HOLD: begin
                if (inst_valid && inst_ready) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (wb_valid) begin
                    next_state = is_word_aligned(wb_dnpc) ? REQ : ERR;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = ERR;
            end
        endcase
    end

    // State, registered handshake/error outputs and the fetch datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
            inst_valid     <= 1'b0;
            fetch_err      <= 1'b0;
            pc             <= RESET_PC;
            inst           <= '0;
            fetch_cnt      <= '0;
        end else begin
            state          <= next_state;
            imem_req_valid <= (next_state == REQ);
            inst_valid     <= (next_state == HOLD);
            fetch_err      <= (next_state == ERR);
            if ((state == WAIT) && imem_rsp_valid) begin
                inst <= imem_rsp_data;
            end
            if ((state == HOLD) && inst_valid && inst_ready) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((state == EXEC) && wb_valid && is_word_aligned(wb_dnpc)) begin
                pc <= wb_dnpc;
            end
        end
    end

    assign imem_addr = pc;
    assign snpc      = pc + 32'd4;

endmodule

// File: tb/tb_ysyx_25020047_ifu_seq.sv
// Randomized self-checking bench for the sequential fetch unit. The model
// tracks only the architectural view: PC, instruction count and error flag.
module tb_ysyx_25020047_ifu_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        wb_valid;
    logic [31:0] wb_dnpc;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    ysyx_25020047_ifu_seq #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO),
        .CNT_W    (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .snpc           (snpc),
        .wb_valid       (wb_valid),
        .wb_dnpc        (wb_dnpc),
        .fetch_err      (fetch_err),
        .fetch_cnt      (fetch_cnt)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        wb_valid       = 1'b0;
        wb_dnpc        = '0;
        tick();
        tick();
        rst     = 1'b0;
        exp_pc  = RST_PC;
        exp_cnt = 0;
    endtask

    // One complete fetch with configurable stalls; noise drives inputs that must be ignored.
    task automatic fetch_one(input int req_wait, input int rsp_wait, input int ack_wait,
                             input logic [31:0] word, input bit noise);
        checks++; if ({imem_req_valid, inst_valid} !== 2'b10 || imem_addr !== exp_pc) begin errors++;
            $display("[TB] FAIL req_entry: req/inst_valid=%b addr=%h, expected 10 addr=%h", {imem_req_valid, inst_valid}, imem_addr, exp_pc); end
        for (int i = 0; i < req_wait; i++) begin
            imem_req_ready = 1'b0;
            if (noise) begin
                imem_rsp_valid = 1'($urandom_range(0, 1)); imem_rsp_data = $urandom;
                wb_valid = 1'($urandom_range(0, 1)); wb_dnpc = $urandom;
            end
            tick();
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc || pc !== exp_pc) begin errors++;
                $display("[TB] FAIL req_stall: req_valid=%b addr=%h pc=%h, expected 1 %h", imem_req_valid, imem_addr, pc, exp_pc); end
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rsp_data  = $urandom;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        checks++; if ({imem_req_valid, inst_valid, fetch_err} !== 3'b000) begin errors++;
            $display("[TB] FAIL wait_entry: req/inst/err=%b, expected 000", {imem_req_valid, inst_valid, fetch_err}); end
        for (int i = 0; i < rsp_wait; i++) begin
            imem_rsp_data = $urandom;
            if (noise) begin wb_valid = 1'($urandom_range(0, 1)); wb_dnpc = $urandom; end
            tick();
            checks++; if ({inst_valid, fetch_err} !== 2'b00) begin errors++;
                $display("[TB] FAIL wait_stall: inst_valid/err=%b, expected 00", {inst_valid, fetch_err}); end
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        checks++; if (inst_valid !== 1'b1 || inst !== word || pc !== exp_pc || fetch_cnt !== exp_cnt || fetch_err !== 1'b0) begin errors++;
            $display("[TB] FAIL hold_entry: valid=%b inst=%h pc=%h cnt=%0d err=%b, expected 1 %h %h %0d 0",
                     inst_valid, inst, pc, fetch_cnt, fetch_err, word, exp_pc, exp_cnt); end
        for (int i = 0; i < ack_wait; i++) begin
            inst_ready = 1'b0;
            if (noise) begin
                imem_rsp_valid = 1'($urandom_range(0, 1));
                wb_valid = 1'($urandom_range(0, 1)); wb_dnpc = $urandom;
            end
            tick();
            checks++; if (inst_valid !== 1'b1 || inst !== word || pc !== exp_pc || fetch_cnt !== exp_cnt) begin errors++;
                $display("[TB] FAIL hold_stall: valid=%b inst=%h pc=%h cnt=%0d, expected 1 %h %h %0d",
                         inst_valid, inst, pc, fetch_cnt, word, exp_pc, exp_cnt); end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready     = 1'b0;
        wb_valid       = 1'b0;
        imem_rsp_valid = 1'b0;
        exp_cnt        = exp_cnt + 1;
        checks++; if ({imem_req_valid, inst_valid} !== 2'b00 || fetch_cnt !== exp_cnt) begin errors++;
            $display("[TB] FAIL handoff: req/inst=%b cnt=%0d, expected 00 cnt=%0d", {imem_req_valid, inst_valid}, fetch_cnt, exp_cnt); end
    endtask

    // Commit a next PC after some idle cycles in EXEC; misaligned targets are fatal.
    task automatic commit(input logic [31:0] dnpc, input int delay);
        for (int i = 0; i < delay; i++) begin
            wb_valid       = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            tick();
            checks++; if ({imem_req_valid, inst_valid, fetch_err} !== 3'b000 || pc !== exp_pc) begin errors++;
                $display("[TB] FAIL exec_idle: req/inst/err=%b pc=%h, expected 000 %h", {imem_req_valid, inst_valid, fetch_err}, pc, exp_pc); end
        end
        imem_rsp_valid = 1'b0;
        wb_valid       = 1'b1;
        wb_dnpc        = dnpc;
        tick();
        wb_valid = 1'b0;
        if (dnpc % 4 == 0) begin
            exp_pc = dnpc;
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc || snpc !== exp_pc + 32'd4 || fetch_err !== 1'b0) begin errors++;
                $display("[TB] FAIL commit: req=%b addr=%h snpc=%h err=%b, expected 1 %h %h 0",
                         imem_req_valid, imem_addr, snpc, fetch_err, exp_pc, exp_pc + 32'd4); end
        end else begin
            checks++; if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0 || pc !== exp_pc) begin errors++;
                $display("[TB] FAIL misaligned: err=%b req=%b pc=%h, expected 1 0 %h", fetch_err, imem_req_valid, pc, exp_pc); end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({imem_req_valid, inst_valid, fetch_err} !== 3'b100 || pc !== RST_PC || imem_addr !== RST_PC
                      || snpc !== RST_PC + 32'd4 || fetch_cnt !== 32'd0) begin errors++;
            $display("[TB] FAIL reset: req/inst/err=%b pc=%h addr=%h snpc=%h cnt=%0d, expected 100 %h %h %h 0",
                     {imem_req_valid, inst_valid, fetch_err}, pc, imem_addr, snpc, fetch_cnt, RST_PC, RST_PC, RST_PC + 32'd4); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        fetch_one(0, 0, 0, 32'h0000_0413, 1'b0);
        checks++; if (snpc !== 32'h8000_0004) begin errors++;
            $display("[TB] FAIL zero_wait_snpc: got %h expected 80000004", snpc); end
    endtask

    task automatic test_backpressure();
        commit(32'h8000_0100, 2);
        fetch_one(3, 1, 4, $urandom, 1'b1);
        commit(32'h8000_0200, 0);
    endtask

    task automatic test_random();
        logic [31:0] dnpc;
        for (int n = 0; n < 20; n++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, 3), $urandom, 1'b1);
            dnpc = (n == 10) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            commit(dnpc, $urandom_range(0, 3));
            if (n == 10) begin
                checks++; if (snpc !== 32'h0000_0000) begin errors++;
                    $display("[TB] FAIL snpc_wrap: got %h expected 00000000", snpc); end
            end
        end
    endtask

    task automatic test_misaligned();
        fetch_one(0, 0, 0, $urandom, 1'b0);
        commit(32'h8000_0102, 1);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; inst_ready = 1'b1;
            wb_valid = 1'b1; wb_dnpc = 32'h8000_0000;
            tick();
            checks++; if ({imem_req_valid, inst_valid, fetch_err} !== 3'b001 || pc !== exp_pc) begin errors++;
                $display("[TB] FAIL err_sticky: req/inst/err=%b pc=%h, expected 001 %h", {imem_req_valid, inst_valid, fetch_err}, pc, exp_pc); end
        end
        do_reset();
        checks++; if (fetch_err !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin errors++;
            $display("[TB] FAIL err_recover: err=%b req=%b addr=%h, expected 0 1 %h", fetch_err, imem_req_valid, imem_addr, RST_PC); end
    endtask

    task automatic test_timeout();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            checks++; if (fetch_err !== 1'b0) begin errors++;
                $display("[TB] FAIL timeout_early: wait cycle %0d err=%b, expected 0", i + 2, fetch_err); end
        end
        tick();
        checks++; if ({imem_req_valid, inst_valid, fetch_err} !== 3'b001) begin errors++;
            $display("[TB] FAIL timeout_expire: req/inst/err=%b, expected 001", {imem_req_valid, inst_valid, fetch_err}); end
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || fetch_err !== 1'b1) begin errors++;
            $display("[TB] FAIL timeout_late_rsp: inst_valid=%b err=%b, expected 0 1", inst_valid, fetch_err); end
        do_reset();
        fetch_one(0, TO - 1, 0, 32'hDEAD_BEE3, 1'b0);
        commit(32'h8000_0040, 0);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        fetch_one(0, 1, 0, $urandom, 1'b0);
        commit(32'h8000_0800, 0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_pc  = RST_PC;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            tick();
            checks++; if ({imem_req_valid, inst_valid} !== 2'b10 || pc !== RST_PC || fetch_cnt !== 32'd0) begin errors++;
                $display("[TB] FAIL reset_in_wait: req/inst=%b pc=%h cnt=%0d, expected 10 %h 0", {imem_req_valid, inst_valid}, pc, fetch_cnt, RST_PC); end
        end
        imem_rsp_valid = 1'b0;
        fetch_one(1, 0, 1, $urandom, 1'b1);
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting ysyx_25020047_ifu_seq bench");
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_random();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
